// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
// Purpose: FSM state encoding, default timeouts and counter-width helper.
// Ports: none (package).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DEF_ACK_TIMEOUT  = 8;
  localparam int DEF_LOCK_TIMEOUT = 4096;

  // Counters only ever hold 0..limit-1, so $clog2(limit) bits suffice.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

  localparam int DEF_ACK_CNT_W  = cnt_width(DEF_ACK_TIMEOUT);
  localparam int DEF_LOCK_CNT_W = cnt_width(DEF_LOCK_TIMEOUT);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter handshake bundle
// Purpose: groups the requester byte streams and the transmitter pins.
// Signals:
//   req_valid/req_data/req_last  requester byte offers (packed, requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS])
//   req_ready                    per-requester acceptance strobe
//   uart_tx_busy                 transmitter busy
//   uart_tx_en/uart_tx_data      transmitter send strobe and byte
// Modports: master = requesters + transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ         = 2,
  parameter int PAYLOAD_BITS = 8
);
  logic [NREQ-1:0]              req_valid;
  logic [NREQ*PAYLOAD_BITS-1:0] req_data;
  logic [NREQ-1:0]              req_last;
  logic [NREQ-1:0]              req_ready;
  logic                         uart_tx_busy;
  logic                         uart_tx_en;
  logic [PAYLOAD_BITS-1:0]      uart_tx_data;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_en, uart_tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_en, uart_tx_data
  );
endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
// Purpose: selects the first set bit of valid scanning upward from ptr, with wrap.
// Ports:
//   valid  in   NREQ  candidate vector
//   ptr    in   IW    highest-priority index
//   pick   out  NREQ  one-hot winner
//   idx    out  IW    winner index
//   any    out  1     a winner exists
module uart_rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] c;

  // Scan from the farthest offset down so the nearest hit to ptr is written last.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    c    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = IW'((int'(ptr) + k) % NREQ);
      if (valid[c]) begin
        any     = 1'b1;
        idx     = c;
        pick    = '0;
        pick[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
// Purpose: accepts one byte at a time from NREQ requesters, with packet lock,
//          and sequences the transmitter enable/busy handshake.
// Ports:
//   clk          in   1     system clock
//   reset        in   1     asynchronous active-high reset
//   bus          slave      requester streams + transmitter pins (uart_tx_arbiter_if)
//   grant        out  NREQ  one-hot current owner
//   lock_active  out  1     packet lock held
//   err_noack    out  1     one-cycle pulse when busy never rose after an enable
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int PAYLOAD_BITS = 8,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_arbiter_if.slave bus,
  output logic [NREQ-1:0] grant,
  output logic            lock_active,
  output logic            err_noack
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int ACW = cnt_width(ACK_TIMEOUT);
  localparam int LCW = cnt_width(LOCK_TIMEOUT);
  localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_TIMEOUT - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   ptr, owner;
  logic [ACW-1:0]  ack_cnt;
  logic [LCW-1:0]  lock_cnt;
  logic [NREQ-1:0] cand_valid, pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept, ack_expire, lock_expire, lock_tick, frame_end;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // While locked only the owner may compete, so ptr is irrelevant then.
  assign cand_valid = lock_active ? (bus.req_valid & (NREQ'(1) << owner)) : bus.req_valid;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (cand_valid),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    ack_expire    = 1'b0;
    lock_expire   = 1'b0;
    lock_tick     = 1'b0;
    frame_end     = 1'b0;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (!bus.uart_tx_busy) begin
          if (pick_any) begin
            accept        = 1'b1;
            bus.req_ready = pick;
            state_nxt     = SEND;
          end else if (lock_active && LOCK_TIMEOUT != 0 && !bus.req_valid[owner]) begin
            if (lock_cnt == LOCK_LAST) lock_expire = 1'b1;
            else                       lock_tick   = 1'b1;
          end
        end
      end
      SEND: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          ack_expire = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      owner            <= '0;
      ack_cnt          <= '0;
      lock_cnt         <= '0;
      grant            <= '0;
      lock_active      <= 1'b0;
      err_noack        <= 1'b0;
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= '0;
    end else begin
      state          <= state_nxt;
      bus.uart_tx_en <= accept;
      err_noack      <= ack_expire;

      // The enable cycle counts as the first cycle without acknowledge.
      if (state == SEND)                                ack_cnt <= ACW'(1);
      else if (state == WAIT_BUSY && !bus.uart_tx_busy) ack_cnt <= ack_cnt + 1'b1;

      // A dropped byte (no acknowledge) releases the grant like a finished frame.
      if ((frame_end || ack_expire) && !lock_active) grant <= '0;

      if (accept) begin
        bus.uart_tx_data <= bus.req_data[int'(pick_idx) * PAYLOAD_BITS +: PAYLOAD_BITS];
        grant            <= pick;
        lock_cnt         <= '0;
        if (bus.req_last[pick_idx]) begin
          lock_active <= 1'b0;
          ptr         <= next_idx(pick_idx);
        end else begin
          lock_active <= 1'b1;
          owner       <= pick_idx;
        end
      end else if (lock_expire) begin
        lock_active <= 1'b0;
        grant       <= '0;
        lock_cnt    <= '0;
        ptr         <= next_idx(owner);
      end else if (lock_tick) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int FRAME = 4;   // busy-high cycles per byte in the transmitter model
  localparam int HN    = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       lock_active;
  logic       err_noack;

  uart_tx_arbiter_if #(.NREQ(2), .PAYLOAD_BITS(8)) bus ();

  uart_tx_arbiter #(
    .NREQ(2), .PAYLOAD_BITS(8), .ACK_TIMEOUT(8), .LOCK_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .grant       (grant),
    .lock_active (lock_active),
    .err_noack   (err_noack)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after en and stays high FRAME cycles.
  logic busy_q     = 1'b0;
  int   frame_cnt  = 0;
  logic model_on   = 1'b1;
  logic busy_force = 1'b0;
  assign bus.uart_tx_busy = busy_q;

  always @(posedge clk) begin
    if (!model_on) begin
      busy_q    <= busy_force;
      frame_cnt <= 0;
    end else if (bus.uart_tx_en) begin
      busy_q    <= 1'b1;
      frame_cnt <= FRAME - 1;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
    end else begin
      busy_q <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] tx_log[$];
  int         acc_log[$];

  logic [1:0] s_ready, s_grant;
  logic       s_en, s_lock, s_err, s_busy;
  logic [7:0] s_data;

  logic [1:0] ready_hist [0:HN-1];
  logic [1:0] grant_hist [0:HN-1];
  logic       lock_hist  [0:HN-1];
  logic       err_hist   [0:HN-1];
  logic       busy_hist  [0:HN-1];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic present();
    bus.req_valid    = {q1.size() != 0, q0.size() != 0};
    bus.req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    bus.req_last[0]    = (q0.size() != 0) ? q0[0][8]   : 1'b0;
    bus.req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
    bus.req_last[1]    = (q1.size() != 0) ? q1[0][8]   : 1'b0;
  endtask

  // One clock: sample at negedge, then update requesters just after the posedge.
  task automatic step();
    @(negedge clk);
    s_ready = bus.req_ready;
    s_en    = bus.uart_tx_en;
    s_data  = bus.uart_tx_data;
    s_grant = grant;
    s_lock  = lock_active;
    s_err   = err_noack;
    s_busy  = bus.uart_tx_busy;
    if (cyc < HN) begin
      ready_hist[cyc] = s_ready;
      grant_hist[cyc] = s_grant;
      lock_hist[cyc]  = s_lock;
      err_hist[cyc]   = s_err;
      busy_hist[cyc]  = s_busy;
    end
    if (s_en) tx_log.push_back(s_data);
    if (s_ready != 2'b00) acc_log.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (s_ready[0] && q0.size() != 0) void'(q0.pop_front());
    if (s_ready[1] && q1.size() != 0) void'(q1.pop_front());
    present();
  endtask

  task automatic run_tx(input string tag, input int n, input int budget);
    int b = 0;
    while (tx_log.size() < n && b < budget) begin
      step();
      b++;
    end
    check(tag, tx_log.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    present();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tx_log.delete();
    acc_log.delete();
  endtask

  initial begin
    int a, b, e, f, t, cnt;
    logic [7:0] exp2 [4];
    logic [1:0] who2 [4];
    exp2 = '{8'h10, 8'h20, 8'h10, 8'h20};
    who2 = '{2'b01, 2'b10, 2'b01, 2'b10};

    // Reset values
    reset = 1'b1;
    present();
    repeat (2) @(posedge clk);
    #1;
    check("rst_en",    int'(bus.uart_tx_en),   0);
    check("rst_data",  int'(bus.uart_tx_data), 0);
    check("rst_grant", int'(grant),            0);
    check("rst_lock",  int'(lock_active),      0);
    check("rst_err",   int'(err_noack),        0);
    check("rst_ready", int'(bus.req_ready),    0);
    reset = 1'b0;

    // 1: single byte from r0
    q0.push_back(9'h141);
    present();
    t = 0;
    while (acc_log.size() == 0 && t < 20) begin step(); t++; end
    check("t1_accept", acc_log.size(), 1);
    a = (acc_log.size() != 0) ? acc_log[0] : cyc;
    check("t1_ready", int'(ready_hist[a]), 2'b01);
    step();
    check("t1_en",         int'(s_en),    1);
    check("t1_data",       int'(s_data),  8'h41);
    check("t1_ready_drop", int'(s_ready), 0);
    repeat (7) step();
    for (int k = 1; k <= 7; k++)
      check($sformatf("t1_grant_%0d", k), int'(grant_hist[a + k]), (k <= 6) ? 2'b01 : 2'b00);
    for (int k = 0; k <= 8; k++) check($sformatf("t1_err_%0d", k), int'(err_hist[a + k]), 0);

    // 2: two single-byte streams alternate, one frame apart
    do_reset();
    q0.push_back(9'h110); q0.push_back(9'h110);
    q1.push_back(9'h120); q1.push_back(9'h120);
    present();
    run_tx("t2_tx", 4, 60);
    check("t2_nacc", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++)
      check($sformatf("t2_byte_%0d", i), int'(tx_log[i]), int'(exp2[i]));
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check($sformatf("t2_who_%0d", i), int'(ready_hist[acc_log[i]]), int'(who2[i]));
    for (int i = 1; i < 4 && i < acc_log.size(); i++)
      check($sformatf("t2_gap_%0d", i), acc_log[i] - acc_log[i-1], 7);

    // 3: locked two-byte packet from r0 is not interleaved with r1
    do_reset();
    q0.push_back(9'h041); q0.push_back(9'h142);
    q1.push_back(9'h15A);
    present();
    run_tx("t3_tx", 3, 60);
    if (tx_log.size() >= 3) begin
      check("t3_byte0", int'(tx_log[0]), 8'h41);
      check("t3_byte1", int'(tx_log[1]), 8'h42);
      check("t3_byte2", int'(tx_log[2]), 8'h5A);
    end
    if (acc_log.size() >= 2) begin
      a = acc_log[0];
      b = acc_log[1];
      check("t3_gap",       b - a, 7);
      check("t3_lock_pre",  int'(lock_hist[a]),     0);
      check("t3_lock_on",   int'(lock_hist[a + 1]), 1);
      check("t3_lock_hold", int'(lock_hist[b]),     1);
      check("t3_lock_off",  int'(lock_hist[b + 1]), 0);
    end

    // 4: owner abandons a locked packet; lock times out after 16 idle cycles
    do_reset();
    q0.push_back(9'h033);
    q1.push_back(9'h144);
    present();
    run_tx("t4_tx", 2, 80);
    a = (acc_log.size() != 0) ? acc_log[0] : 0;
    f = -1;
    for (int c = a + 2; c < cyc && c < HN; c++)
      if (f < 0 && busy_hist[c] == 1'b0 && busy_hist[c-1] == 1'b1) f = c;
    check("t4_frame", f - a, 6);
    if (f < 0) f = a + 6;
    // WAIT_DONE sees busy low at f; IDLE cycles f+1..f+16 count; lock drops at f+17.
    check("t4_lock_hold",  int'(lock_hist[f + 16]),  1);
    check("t4_lock_off",   int'(lock_hist[f + 17]),  0);
    check("t4_grant_hold", int'(grant_hist[f + 16]), 2'b01);
    check("t4_grant_off",  int'(grant_hist[f + 17]), 0);
    check("t4_ready_r1",   int'(ready_hist[f + 17]), 2'b10);
    if (acc_log.size() >= 2) check("t4_acc_cyc", acc_log[1], f + 17);
    if (tx_log.size() >= 2) begin
      check("t4_byte0", int'(tx_log[0]), 8'h33);
      check("t4_byte1", int'(tx_log[1]), 8'h44);
    end

    // 5: transmitter never acknowledges
    model_on   = 1'b0;
    busy_force = 1'b0;
    do_reset();
    q0.push_back(9'h155); q0.push_back(9'h166);
    present();
    run_tx("t5_tx", 2, 40);
    e = ((acc_log.size() != 0) ? acc_log[0] : 0) + 1;
    check("t5_err_pre",   int'(err_hist[e + 7]),   0);
    check("t5_err_pulse", int'(err_hist[e + 8]),   1);
    check("t5_err_post",  int'(err_hist[e + 9]),   0);
    check("t5_grant_off", int'(grant_hist[e + 8]), 0);
    if (acc_log.size() >= 2) check("t5_next_acc", acc_log[1], e + 8);
    if (tx_log.size() >= 2) check("t5_byte1", int'(tx_log[1]), 8'h66);
    model_on = 1'b1;

    // 6: reset while the transmitter is mid-frame
    do_reset();
    q0.push_back(9'h171);
    present();
    t = 0;
    while (acc_log.size() == 0 && t < 20) begin step(); t++; end
    repeat (3) step();
    check("t6_pre_grant", int'(grant), 2'b01);
    check("t6_pre_data",  int'(bus.uart_tx_data), 8'h71);
    model_on   = 1'b0;
    busy_force = 1'b1;
    reset      = 1'b1;
    #1;
    check("t6_rst_en",    int'(bus.uart_tx_en),   0);
    check("t6_rst_data",  int'(bus.uart_tx_data), 0);
    check("t6_rst_grant", int'(grant),            0);
    check("t6_rst_lock",  int'(lock_active),      0);
    check("t6_rst_err",   int'(err_noack),        0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tx_log.delete();
    acc_log.delete();
    q0.push_back(9'h1A0);
    q1.push_back(9'h1B0);
    present();
    cnt = 0;
    repeat (5) begin
      step();
      if (s_ready != 2'b00) cnt++;
    end
    check("t6_no_ready_busy", cnt, 0);
    busy_force = 1'b0;
    t = 0;
    while (acc_log.size() == 0 && t < 10) begin step(); t++; end
    check("t6_ready",    int'(s_ready), 2'b01);
    check("t6_busy_low", int'(s_busy),  0);
    run_tx("t6_tx", 1, 20);
    if (tx_log.size() >= 1) check("t6_byte", int'(tx_log[0]), 8'hA0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8-bit UART transmitter between NREQ byte-stream requesters, e.g. the CPU bus write path and a hardware debug monitor.
- Round-robin arbitration, with optional packet lock so that multi-byte messages from one source are not interleaved.
- Sequences the transmitter handshake: one-cycle enable pulse, wait for busy rise, wait for busy fall.
- Sits between the requesters and the transmitter's uart_tx_en/uart_tx_data/uart_tx_busy pins.

Parameters:
- NREQ, 2, number of requesters (2..8).
- PAYLOAD_BITS, 8, byte width.
- ACK_TIMEOUT, 8, cycles to wait for busy to rise after an enable pulse.
- LOCK_TIMEOUT, 4096, idle cycles before a held lock is force-released; 0 = never release.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  byte offered per requester
- req_data  in  NREQ*PAYLOAD_BITS  packed bytes, requester i at bits [i*8+:8]
- req_last  in  NREQ  offered byte ends the packet
- req_ready  out  NREQ  byte accepted this cycle (combinational)
- uart_tx_busy  in  1  transmitter busy
- uart_tx_en  out  1  one-cycle send strobe, registered
- uart_tx_data  out  PAYLOAD_BITS  byte to send, registered
- grant  out  NREQ  one-hot current owner
- lock_active  out  1  packet lock held
- err_noack  out  1  one-cycle pulse on transmitter no-acknowledge

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, uart_tx_en=0, uart_tx_data=0, grant=0, lock_active=0, err_noack=0.
  - rr pointer=0; both counters=0.
- IDLE, candidate selection:
  - If lock_active, the only candidate is the owner.
  - Otherwise, the first valid requester scanning from ptr upward, with wrap.
- IDLE, acceptance:
  - Occurs only when uart_tx_busy=0 and a candidate exists.
  - req_ready[i]=1 for that one cycle only; ready is 0 in every other state.
  - On that edge: uart_tx_data<=byte, grant<=onehot(i), state->SEND.
- Requester rules: valid must not depend on ready; data and last are held until ready.
- SEND: uart_tx_en=1 for exactly one cycle, state->WAIT_BUSY. Data stays stable until the next acceptance.
- WAIT_BUSY:
  - busy=1 -> WAIT_DONE.
  - ACK_TIMEOUT cycles with busy=0 -> err_noack pulse, state->IDLE. The byte is dropped; lock bookkeeping proceeds as if it had been sent.
- WAIT_DONE: busy=0 -> IDLE. grant is cleared here unless lock_active.
- Nominal latency: ready at T, en at T+1, busy seen at T+2. Back-to-back bytes are accepted on the first IDLE cycle with busy=0.
- Lock bookkeeping (applied at acceptance):
  - last=0: lock_active=1, owner=i, lock counter cleared.
  - last=1: lock_active=0, ptr=(i+1) mod NREQ.
  - ptr is unchanged while locked.
- Lock timeout:
  - While in IDLE with lock_active and owner valid=0, the counter increments.
  - On reaching LOCK_TIMEOUT (nonzero): lock_active=0, grant=0, ptr=owner+1.
  - Counter is cleared on any owner acceptance.
- Simultaneous valid requests: resolved by ptr. Single-byte packets from all sources alternate strictly.
- Busy high in IDLE (transmitter still finishing, or after reset): no acceptance and no counter advance.
- Reset mid-frame: outputs drop at once. The transmitter may still be busy; the first acceptance waits for busy=0.
- Requester deasserting valid while locked: allowed, handled by the lock timeout.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding IDLE/SEND/WAIT_BUSY/WAIT_DONE (2-bit);
  - default timeouts;
  - counter widths as $clog2 of the timeouts.
- One sub-module, uart_rr_pick: combinational round-robin picker.
  - Inputs: valid vector, ptr.
  - Outputs: one-hot pick, index, any.

Test Plan:
- Reset, then r0 offers 0x41 last=1 -> req_ready=01 for 1 cycle; next cycle uart_tx_en=1 with data 0x41; grant=01 until busy falls, then 00; err_noack stays 0.
- r0=0x10 and r1=0x20, both last=1 and continuously valid, 4 bytes -> transmitted order 10,20,10,20; each req_ready pulse separated by a full frame.
- r0 sends 'A'(last=0), 'B'(last=1) while r1 holds 0x5A valid -> order 41,42,5A; lock_active high from acceptance of 41 until acceptance of 42.
- LOCK_TIMEOUT=16: r0 sends 0x33 last=0 then drops valid; r1 valid 0x44 -> lock_active falls exactly 16 IDLE cycles after busy falls; 0x44 accepted the next cycle.
- uart_tx_busy tied 0, ACK_TIMEOUT=8: r0 sends 0x55 -> err_noack pulses 8 cycles after the en cycle; state back to IDLE; next byte 0x66 accepted on the following cycle.
- Assert reset while busy is held high by the transmitter model -> all outputs 0 immediately; after release, no req_ready until busy=0, then r0 byte accepted with ptr=0.
